fec_mem_engine: RTL

- Parametrised memory-to-memory Hamming SECDED (16,11) engine; successor to the single-message encoder path in top_level.
- Processes a block of NUM_WORDS messages per start in one of two modes: ENCODE (11-bit message -> 16-bit codeword) or DECODE (16-bit codeword -> corrected 11-bit message + status).
- Sits between the controller and data memory; owns one synchronous single-port memory port; raises done when the whole block is written.

---
 rtl/fec_mem_engine.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fec_mem_engine.sv
// fec_mem_engine: block-oriented Hamming SECDED (16,11) encoder/decoder that
// walks num_words little-endian 16-bit words from SRC_BASE, converts each one
// and writes it to DST_BASE over a synchronous single-port byte memory.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   start      one-cycle request, honoured only in IDLE or DONE
//   mode       0 = ENCODE, 1 = DECODE (latched on start)
//   num_words  block length, clamped to MAX_WORDS (latched on start)
//   mem_addr   memory byte address
//   mem_wr_en  memory write strobe
//   mem_wdata  memory write data
//   mem_rdata  memory read data, one cycle after mem_addr
//   busy       block in progress
//   done       block complete, held until the next start
//   corr_count DECODE words with a corrected single error (saturating)
//   dbl_count  DECODE words with a detected double error (saturating)
//
// state | meaning
// IDLE  | waiting for start after reset
// RLO   | source low byte address on the bus
// RHI   | source high byte address on the bus, low byte arriving
// CAP   | high byte arriving, result computed
// WLO   | writing result low byte
// WHI   | writing result high byte, advance word index
// DONE  | block finished, done held, waiting for start
module fec_mem_engine #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 15,
   parameter int SRC_BASE  = 0,
   parameter int DST_BASE  = 30,
   localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [CNT_W-1:0]  num_words,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  corr_count,
   output logic [CNT_W-1:0]  dbl_count
);

   typedef enum logic [2:0] {IDLE, RLO, RHI, CAP, WLO, WHI, DONE} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   state_t           state;
   logic             mode_q;
   logic [CNT_W-1:0] nw_q;
   logic [CNT_W-1:0] idx;
   logic [CNT_W-1:0] idx_nxt;
   logic [7:0]       lo_q;
   logic [7:0]       res_hi_q;

   logic [15:0] cw;
   logic [15:0] fixed;
   logic [3:0]  syn;
   logic        overall;
   logic [1:0]  flags;
   logic [15:0] result;

   function automatic logic [15:0] encode(input logic [10:0] m);
      logic [15:0] c;
      c       = '0;
      c[3]    = m[0];
      c[7:5]  = m[3:1];
      c[15:9] = m[10:4];
      c[1]    = c[3] ^ c[5] ^ c[7] ^ c[9]  ^ c[11] ^ c[13] ^ c[15];
      c[2]    = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
      c[4]    = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
      c[8]    = ^c[15:9];
      c[0]    = ^c[15:1];
      return c;
   endfunction

   // Byte address of word i (hi selects the upper byte), wrapping at 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] byte_addr(input int base,
                                                   input logic [CNT_W-1:0] i,
                                                   input logic hi);
      return ADDR_W'(base) + ADDR_W'({i, hi});
   endfunction

   assign idx_nxt = idx + 1'b1;

   // Result is computed in CAP from the captured low byte and the high byte
   // currently on mem_rdata, so it can be registered straight into WLO.
   always_comb begin
      cw      = {mem_rdata, lo_q};
      syn     = '0;
      for (int k = 1; k < 16; k++) begin
         if (cw[k]) syn = syn ^ 4'(k);
      end
      overall = ^cw;
      fixed   = cw;
      if (overall) fixed[syn] = ~fixed[syn];
      flags   = 2'b00;
      if (overall)          flags = 2'b01;
      else if (syn != 4'd0) flags = 2'b10;
      if (mode_q)
         result = {flags, 3'b000, fixed[15:9], fixed[7:5], fixed[3]};
      else
         result = encode({mem_rdata[2:0], lo_q});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         mode_q     <= 1'b0;
         nw_q       <= '0;
         idx        <= '0;
         lo_q       <= '0;
         res_hi_q   <= '0;
         mem_addr   <= '0;
         mem_wr_en  <= 1'b0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         corr_count <= '0;
         dbl_count  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  done       <= 1'b0;
                  busy       <= 1'b1;
                  corr_count <= '0;
                  dbl_count  <= '0;
                  mode_q     <= mode;
                  nw_q       <= (num_words > MAX_CNT) ? MAX_CNT : num_words;
                  idx        <= '0;
                  mem_addr   <= byte_addr(SRC_BASE, '0, 1'b0);
                  state      <= RLO;
               end
            end
            RLO: begin
               // Empty block: finish without touching memory.
               if (nw_q == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  mem_addr <= byte_addr(SRC_BASE, idx, 1'b1);
                  state    <= RHI;
               end
            end
            RHI: begin
               lo_q  <= mem_rdata;
               state <= CAP;
            end
            CAP: begin
               mem_addr  <= byte_addr(DST_BASE, idx, 1'b0);
               mem_wr_en <= 1'b1;
               mem_wdata <= result[7:0];
               res_hi_q  <= result[15:8];
               if (mode_q && flags == 2'b01 && corr_count != MAX_CNT)
                  corr_count <= corr_count + 1'b1;
               if (mode_q && flags == 2'b10 && dbl_count != MAX_CNT)
                  dbl_count <= dbl_count + 1'b1;
               state <= WLO;
            end
            WLO: begin
               mem_addr  <= byte_addr(DST_BASE, idx, 1'b1);
               mem_wdata <= res_hi_q;
               state     <= WHI;
            end
            WHI: begin
               mem_wr_en <= 1'b0;
               idx       <= idx_nxt;
               if (idx_nxt == nw_q) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  mem_addr <= byte_addr(SRC_BASE, idx_nxt, 1'b0);
                  state    <= RLO;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
